// File: rtl/defines_pkg.sv
// Shared definitions for the local store (LS) and its fetch burst engine.
//   LS_SIZE    : default store capacity in bytes
//   LSLOADFILE : name of the hex image associated with the quadword RAM
//   LS_PRELOAD_EN : preload enable flag for the quadword RAM
//   QW_BYTES   : bytes per quadword (one RAM word)
//   burst_state_e : burst engine states (LS_IDLE, LS_BURST)
package defines_pkg;

  localparam int unsigned LS_SIZE       = 4096;
  localparam string       LSLOADFILE    = "ls_init.hex";
  localparam bit          LS_PRELOAD_EN = 1'b0;
  localparam int unsigned QW_BYTES      = 16;

  typedef enum logic {
    LS_IDLE,
    LS_BURST
  } burst_state_e;

endpackage

// File: rtl/ls_qw_ram.sv
// Single-ported 128-bit quadword RAM with per-byte write enables and a one-cycle registered
// read. At most one access per cycle; the read register only updates on a read.
// Ports:
//   clk   : clock
//   en    : access enable
//   we    : 1 = write, 0 = read (when en = 1)
//   idx   : quadword index
//   wdata : write quadword (most significant byte is LS byte 0)
//   be    : byte enables, be[15] covers wdata[127:120] (LS byte 0)
//   rdata : read data, valid the cycle after a read access
// Contents are never reset.
module ls_qw_ram
  import defines_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter bit          PRELOAD   = LS_PRELOAD_EN,
  parameter string       LOAD_FILE = LSLOADFILE
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [127:0]             wdata,
  input  logic [15:0]              be,
  output logic [127:0]             rdata
);

  logic [127:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 16; i++) begin
          if (be[i]) begin
            mem[idx][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/ls_arb_store.sv
// Local store with a load/store port and an instruction-fetch burst port sharing one
// single-ported quadword RAM. Load/store always wins arbitration; a contended fetch beat is
// simply retried on the next free cycle. Reads return one cycle after they are issued.
//
// Vectors are numbered MSB-first in the architecture: LS byte 0 is the most significant byte
// of a quadword and ls_byte_en's most significant bit enables it. Here they are declared
// [N-1:0] with identical numeric values, so byte 0 sits at [127:120] and ls_byte_en[15].
//
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   ls_req_valid    : load/store request (ls_req_ready is tied to 1)
//   ls_wr_en        : 1 = write, 0 = read
//   ls_addr         : byte address, low 4 bits ignored, wraps modulo LS_BYTES
//   ls_data_wr      : write quadword
//   ls_byte_en      : per-byte write enables
//   ls_rvalid       : read response valid; ls_data_rd holds otherwise
//   ls_data_rd      : read response data
//   if_req_valid    : fetch burst request, accepted when if_req_ready = 1
//   if_addr         : burst start address, aligned down to a quadword
//   if_rvalid       : fetch beat valid; if_rdata holds otherwise
//   if_rdata        : fetch beat data
//   if_rlast        : last beat of the burst (qualified by if_rvalid)
//
// Build option: LS_BYTE_MASK_EN -- when defined, ls_byte_en masks writes per byte; when
// undefined, every write replaces the whole quadword.
module ls_arb_store
  import defines_pkg::*;
#(
  parameter int unsigned LS_BYTES    = LS_SIZE,
  parameter int unsigned FETCH_BEATS = 4,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_wr_en,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [127:0]      ls_data_wr,
  input  logic [15:0]       ls_byte_en,
  output logic              ls_rvalid,
  output logic [127:0]      ls_data_rd,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rvalid,
  output logic [127:0]      if_rdata,
  output logic              if_rlast
);

  localparam int unsigned DEPTH = LS_BYTES / QW_BYTES;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(FETCH_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FETCH_BEATS - 1);

  burst_state_e     state_q, state_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ls_rd_q, if_rd_q, if_last_q;
  logic [127:0]     ls_hold_q, if_hold_q;

  logic [IDX_W-1:0] ls_idx, if_idx, beat_idx, ram_idx;
  logic             if_access, if_last_beat;
  logic             ram_en, ram_we;
  logic [15:0]      ram_be;
  logic [127:0]     ram_rdata;

  // Only the quadword index field of each address is used; the rest is ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ls_addr, if_addr};

  assign ls_req_ready = 1'b1;

  // Dropping the upper address bits gives the modulo-depth wrap for free.
  assign ls_idx   = ls_addr[IDX_W+3:4];
  assign if_idx   = if_addr[IDX_W+3:4];
  assign beat_idx = base_q + IDX_W'(cnt_q);

`ifdef LS_BYTE_MASK_EN
  assign ram_be = ls_byte_en;
`else
  logic unused_byte_en;
  assign unused_byte_en = ^ls_byte_en;
  assign ram_be         = '1;
`endif

  // Burst engine: next state, beat issue and the last-beat flag.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    if_req_ready = 1'b0;
    if_access    = 1'b0;
    if_last_beat = 1'b0;
    unique case (state_q)
      LS_IDLE: begin
        if_req_ready = 1'b1;
        if (if_req_valid) begin
          base_d  = if_idx;
          cnt_d   = '0;
          state_d = LS_BURST;
        end
      end
      LS_BURST: begin
        // A load/store request steals the cycle; the counter holds until a free one.
        if (!ls_req_valid) begin
          if_access    = 1'b1;
          if_last_beat = (cnt_q == LAST_BEAT);
          cnt_d        = cnt_q + 1'b1;
          if (if_last_beat) begin
            cnt_d   = '0;
            state_d = LS_IDLE;
          end
        end
      end
      default: state_d = LS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LS_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single RAM port: load/store has fixed priority over the burst engine.
  assign ram_en  = ls_req_valid | if_access;
  assign ram_we  = ls_req_valid & ls_wr_en;
  assign ram_idx = ls_req_valid ? ls_idx : beat_idx;

  ls_qw_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .idx  (ram_idx),
    .wdata(ls_data_wr),
    .be   (ram_be),
    .rdata(ram_rdata)
  );

  // Response tags follow the RAM read by one cycle; hold registers keep the last data so the
  // outputs stay stable while their valid is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ls_rd_q   <= 1'b0;
      if_rd_q   <= 1'b0;
      if_last_q <= 1'b0;
      ls_hold_q <= '0;
      if_hold_q <= '0;
    end else begin
      ls_rd_q   <= ls_req_valid & ~ls_wr_en;
      if_rd_q   <= if_access;
      if_last_q <= if_last_beat;
      if (ls_rd_q) begin
        ls_hold_q <= ram_rdata;
      end
      if (if_rd_q) begin
        if_hold_q <= ram_rdata;
      end
    end
  end

  assign ls_rvalid  = ls_rd_q;
  assign ls_data_rd = ls_rd_q ? ram_rdata : ls_hold_q;
  assign if_rvalid  = if_rd_q;
  assign if_rdata   = if_rd_q ? ram_rdata : if_hold_q;
  assign if_rlast   = if_last_q;

endmodule

// File: tb/tb_ls_arb_store.sv
// Self-checking bench for ls_arb_store: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a behavioural model of the store and the fetch rules.
module tb_ls_arb_store;

  localparam int unsigned LS_BYTES    = 4096;
  localparam int unsigned FETCH_BEATS = 4;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DEPTH       = LS_BYTES / 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ls_req_valid = 1'b0;
  logic              ls_req_ready;
  logic              ls_wr_en = 1'b0;
  logic [ADDR_W-1:0] ls_addr = '0;
  logic [127:0]      ls_data_wr = '0;
  logic [15:0]       ls_byte_en = '0;
  logic              ls_rvalid;
  logic [127:0]      ls_data_rd;
  logic              if_req_valid = 1'b0;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_rvalid;
  logic [127:0]      if_rdata;
  logic              if_rlast;

  always #5 clk = ~clk;

  ls_arb_store #(
    .LS_BYTES   (LS_BYTES),
    .FETCH_BEATS(FETCH_BEATS),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ls_req_valid(ls_req_valid),
    .ls_req_ready(ls_req_ready),
    .ls_wr_en    (ls_wr_en),
    .ls_addr     (ls_addr),
    .ls_data_wr  (ls_data_wr),
    .ls_byte_en  (ls_byte_en),
    .ls_rvalid   (ls_rvalid),
    .ls_data_rd  (ls_data_rd),
    .if_req_valid(if_req_valid),
    .if_req_ready(if_req_ready),
    .if_addr     (if_addr),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .if_rlast    (if_rlast)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state.
  logic [127:0] mem_m [DEPTH];
  bit           burst_m = 1'b0;
  int unsigned  base_m  = 0;
  int unsigned  beat_m  = 0;
  logic         exp_ls_rv = 1'b0, exp_if_rv = 1'b0, exp_if_last = 1'b0;
  logic [127:0] exp_ls_data = '0, exp_if_data = '0;

  // Observation log.
  int unsigned  tick_n     = 0;
  int unsigned  beats_seen = 0;
  int unsigned  last_tick  = 0;
  logic [127:0] beat_q [$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned qw(input logic [ADDR_W-1:0] a);
    return (a / 16) % DEPTH;
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] old_d, input logic [127:0] new_d,
                                         input logic [15:0] be);
    logic [127:0] m;
    // Byte 0 is the most significant byte and is enabled by the top bit of be.
    for (int i = 0; i < 16; i++) m[127-8*i -: 8] = {8{be[15-i]}};
`ifndef LS_BYTE_MASK_EN
    m = '1;
`endif
    return (old_d & ~m) | (new_d & m);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_idle();
    ls_req_valid = 1'b0;
    ls_wr_en     = 1'b0;
    if_req_valid = 1'b0;
  endtask

  // One clock cycle: model the inputs currently driven, clock, then compare outputs.
  task automatic tick();
    tick_n++;
    check_eq("if_req_ready", if_req_ready, !burst_m);
    check_eq("ls_req_ready", ls_req_ready, 1'b1);
    exp_ls_rv   = ls_req_valid && !ls_wr_en;
    if (exp_ls_rv) exp_ls_data = mem_m[qw(ls_addr)];
    exp_if_rv   = 1'b0;
    exp_if_last = 1'b0;
    if (burst_m && !ls_req_valid) begin
      exp_if_rv   = 1'b1;
      exp_if_data = mem_m[(base_m + beat_m) % DEPTH];
      exp_if_last = (beat_m == FETCH_BEATS - 1);
      beat_m++;
      if (exp_if_last) burst_m = 1'b0;
    end else if (!burst_m && if_req_valid) begin
      burst_m = 1'b1;
      base_m  = qw(if_addr);
      beat_m  = 0;
    end
    if (ls_req_valid && ls_wr_en)
      mem_m[qw(ls_addr)] = merge(mem_m[qw(ls_addr)], ls_data_wr, ls_byte_en);
    @(posedge clk);
    #1;
    check_eq("ls_rvalid", ls_rvalid, exp_ls_rv);
    check_eq("ls_data_rd", ls_data_rd, exp_ls_data);
    check_eq("if_rvalid", if_rvalid, exp_if_rv);
    check_eq("if_rdata", if_rdata, exp_if_data);
    check_eq("if_rlast", if_rlast, exp_if_last);
    if (if_rvalid) begin
      beats_seen++;
      beat_q.push_back(if_rdata);
      if (if_rlast) last_tick = tick_n;
    end
  endtask

  task automatic ls_wr(input logic [ADDR_W-1:0] a, input logic [127:0] d, input logic [15:0] be);
    ls_req_valid = 1'b1;
    ls_wr_en     = 1'b1;
    ls_addr      = a;
    ls_data_wr   = d;
    ls_byte_en   = be;
    tick();
    set_idle();
  endtask

  task automatic ls_rd(input logic [ADDR_W-1:0] a);
    ls_req_valid = 1'b1;
    ls_wr_en     = 1'b0;
    ls_addr      = a;
    tick();
    set_idle();
  endtask

  task automatic fetch_req(input logic [ADDR_W-1:0] a);
    if_req_valid = 1'b1;
    if_addr      = a;
    tick();
    set_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] pat, pat_lo, exp_v, qv [4];
    int unsigned  req_tick, n0;

    // Reset state.
    #12;
    check_eq("rst_ls_rvalid", ls_rvalid, 1'b0);
    check_eq("rst_ls_data_rd", ls_data_rd, '0);
    check_eq("rst_if_rvalid", if_rvalid, 1'b0);
    check_eq("rst_if_rdata", if_rdata, '0);
    check_eq("rst_if_rlast", if_rlast, 1'b0);
    check_eq("rst_if_req_ready", if_req_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) tick();

    // Fill the whole store so every later read has a known value.
    for (int i = 0; i < DEPTH; i++) ls_wr(ADDR_W'(i * 16), rand128(), 16'hFFFF);

    // Full write, read-back, then a single-byte masked write.
    pat = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    ls_wr(32'h40, pat, 16'hFFFF);
    ls_rd(32'h40);
    check_eq("full_wr_rd", ls_data_rd, pat);
    ls_wr(32'h40, '1, 16'h8000);
    ls_rd(32'h40);
    pat_lo = pat;
`ifdef LS_BYTE_MASK_EN
    exp_v = {8'hFF, pat_lo[119:0]};
`else
    exp_v = '1;
`endif
    check_eq("byte0_wr_rd", ls_data_rd, exp_v);
    repeat (2) tick();
    check_eq("data_hold", ls_data_rd, exp_v);

    // Uncontended burst at 0x100.
    for (int i = 0; i < 4; i++) begin
      qv[i] = rand128();
      ls_wr(ADDR_W'(32'h100 + 16 * i), qv[i], 16'hFFFF);
    end
    beat_q.delete();
    n0 = beats_seen;
    req_tick = tick_n + 1;
    fetch_req(32'h100);
    repeat (FETCH_BEATS + 2) tick();
    check_eq("burst_beats", beats_seen - n0, 4);
    check_eq("burst_last_lat", last_tick - req_tick, FETCH_BEATS);
    for (int i = 0; i < 4; i++)
      if (i < beat_q.size()) check_eq("burst_order", beat_q[i], qv[i]);

    // Same burst with load/store reads stealing the 2nd and 3rd cycles.
    beat_q.delete();
    n0 = beats_seen;
    req_tick = tick_n + 1;
    fetch_req(32'h10C);
    ls_rd(32'h40);
    check_eq("steal_rd0", ls_data_rd, exp_v);
    ls_rd(32'h100);
    check_eq("steal_rd1", ls_data_rd, qv[0]);
    repeat (FETCH_BEATS + 2) tick();
    check_eq("steal_beats", beats_seen - n0, 4);
    check_eq("steal_last_lat", last_tick - req_tick, FETCH_BEATS + 2);
    for (int i = 0; i < 4; i++)
      if (i < beat_q.size()) check_eq("steal_order", beat_q[i], qv[i]);

    // Burst that wraps past the top of the store.
    for (int i = 0; i < 4; i++) begin
      qv[i] = rand128();
      ls_wr(ADDR_W'((LS_BYTES - 32 + 16 * i) % LS_BYTES), qv[i], 16'hFFFF);
    end
    beat_q.delete();
    fetch_req(ADDR_W'(LS_BYTES - 32));
    repeat (FETCH_BEATS + 1) tick();
    check_eq("wrap_beats", beat_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < beat_q.size()) check_eq("wrap_data", beat_q[i], qv[i]);

    // Reset asserted mid-burst, around beat 2.
    fetch_req(32'h300);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_if_rvalid", if_rvalid, 1'b0);
    check_eq("mid_rst_if_rdata", if_rdata, '0);
    check_eq("mid_rst_if_rlast", if_rlast, 1'b0);
    check_eq("mid_rst_ls_rvalid", ls_rvalid, 1'b0);
    check_eq("mid_rst_ls_data_rd", ls_data_rd, '0);
    check_eq("mid_rst_if_req_ready", if_req_ready, 1'b1);
    burst_m     = 1'b0;
    exp_ls_data = '0;
    exp_if_data = '0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    n0 = beats_seen;
    repeat (6) tick();
    check_eq("no_beats_after_rst", beats_seen - n0, 0);
    for (int i = 0; i < 4; i++) ls_rd(ADDR_W'(32'h300 + 16 * i));
    ls_rd(32'h40);
    check_eq("mem_intact", ls_data_rd, exp_v);

    // Randomized mixed traffic.
    for (int c = 0; c < 600; c++) begin
      ls_req_valid = ($urandom_range(0, 2) == 0);
      ls_wr_en     = $urandom_range(0, 1) == 1;
      ls_addr      = $urandom;
      ls_data_wr   = rand128();
      ls_byte_en   = 16'($urandom);
      if_req_valid = ($urandom_range(0, 3) == 0);
      if_addr      = $urandom;
      tick();
    end
    set_idle();
    repeat (FETCH_BEATS + 2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
